// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: ID-side instruction fields in, EX-side registered copies out.
// master = pipeline control/ID stage driving, slave = the ID/EX register.
`ifndef ID_EX_REG_DEFS
`define ID_EX_REG_DEFS
`define ALUOP_WIDTH    4
`define MEM_MODE_WIDTH 3
`define ALU_ADD        4'd0
`define MEM_BYTE       3'd0
`endif

interface id_ex_reg_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
);
    logic                       hold;
    logic                       flush;
    logic                       id_valid;
    logic                       bubble_clr;

    logic                       id_alu_src;
    logic [`ALUOP_WIDTH-1:0]    id_alu_op;
    logic                       id_mem_write;
    logic                       id_mem_read;
    logic [`MEM_MODE_WIDTH-1:0] id_mem_mode;
    logic                       id_mem_to_reg;
    logic                       id_reg_write;

    logic [DATA_WIDTH-1:0]      id_pc;
    logic [DATA_WIDTH-1:0]      id_rs1_data;
    logic [DATA_WIDTH-1:0]      id_rs2_data;
    logic [DATA_WIDTH-1:0]      id_imm;
    logic [REG_ADDR_WIDTH-1:0]  id_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0]  id_rs2_addr;
    logic [REG_ADDR_WIDTH-1:0]  id_rd_addr;

    logic                       ex_alu_src;
    logic [`ALUOP_WIDTH-1:0]    ex_alu_op;
    logic                       ex_mem_write;
    logic                       ex_mem_read;
    logic [`MEM_MODE_WIDTH-1:0] ex_mem_mode;
    logic                       ex_mem_to_reg;
    logic                       ex_reg_write;

    logic [DATA_WIDTH-1:0]      ex_pc;
    logic [DATA_WIDTH-1:0]      ex_rs1_data;
    logic [DATA_WIDTH-1:0]      ex_rs2_data;
    logic [DATA_WIDTH-1:0]      ex_imm;
    logic [REG_ADDR_WIDTH-1:0]  ex_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0]  ex_rs2_addr;
    logic [REG_ADDR_WIDTH-1:0]  ex_rd_addr;

    logic                       ex_valid;
    logic [CNT_WIDTH-1:0]       bubble_cnt;

    modport master (
        output hold, flush, id_valid, bubble_clr,
        output id_alu_src, id_alu_op, id_mem_write, id_mem_read, id_mem_mode,
        output id_mem_to_reg, id_reg_write,
        output id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rs1_addr, id_rs2_addr, id_rd_addr,
        input  ex_alu_src, ex_alu_op, ex_mem_write, ex_mem_read, ex_mem_mode,
        input  ex_mem_to_reg, ex_reg_write,
        input  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
        input  ex_valid, bubble_cnt
    );

    modport slave (
        input  hold, flush, id_valid, bubble_clr,
        input  id_alu_src, id_alu_op, id_mem_write, id_mem_read, id_mem_mode,
        input  id_mem_to_reg, id_reg_write,
        input  id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rs1_addr, id_rs2_addr, id_rd_addr,
        output ex_alu_src, ex_alu_op, ex_mem_write, ex_mem_read, ex_mem_mode,
        output ex_mem_to_reg, ex_reg_write,
        output ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
        output ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
        output ex_valid, bubble_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with squash, freeze and a saturating bubble counter; latency 1, all outputs flopped.
// Backpressure: hold freezes every register; flush overrides hold and squashes the slot.
module id_ex_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_reg_if.slave   bus
);
    typedef struct packed {
        logic                       alu_src;
        logic [`ALUOP_WIDTH-1:0]    alu_op;
        logic                       mem_write;
        logic                       mem_read;
        logic [`MEM_MODE_WIDTH-1:0] mem_mode;
        logic                       mem_to_reg;
        logic                       reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     pc;
        logic [DATA_WIDTH-1:0]     rs1_data;
        logic [DATA_WIDTH-1:0]     rs2_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs1_addr;
        logic [REG_ADDR_WIDTH-1:0] rs2_addr;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
    } data_t;

    localparam ctrl_t CTRL_OFF = '{
        alu_src:    1'b0,
        alu_op:     `ALU_ADD,
        mem_write:  1'b0,
        mem_read:   1'b0,
        mem_mode:   `MEM_BYTE,
        mem_to_reg: 1'b0,
        reg_write:  1'b0
    };

    ctrl_t                ctrl_q, ctrl_d, id_ctrl;
    data_t                data_q, data_d, id_data;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 load;
    logic                 bubble;

    always_comb begin
        id_ctrl = '{
            alu_src:    bus.id_alu_src,
            alu_op:     bus.id_alu_op,
            mem_write:  bus.id_mem_write,
            mem_read:   bus.id_mem_read,
            mem_mode:   bus.id_mem_mode,
            mem_to_reg: bus.id_mem_to_reg,
            reg_write:  bus.id_reg_write
        };
        id_data = '{
            pc:       bus.id_pc,
            rs1_data: bus.id_rs1_data,
            rs2_data: bus.id_rs2_data,
            imm:      bus.id_imm,
            rs1_addr: bus.id_rs1_addr,
            rs2_addr: bus.id_rs2_addr,
            rd_addr:  bus.id_rd_addr
        };
    end

    assign load   = !bus.flush && !bus.hold;
    assign bubble = bus.flush || (load && !bus.id_valid);

    always_comb begin
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (bus.flush) begin
            // Data fields are left alone on a squash; only control is neutralised.
            ctrl_d  = CTRL_OFF;
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = bus.id_valid;
            data_d  = id_data;
            ctrl_d  = bus.id_valid ? id_ctrl : CTRL_OFF;
            if (bus.id_valid && (id_data.rd_addr == '0)) begin
                ctrl_d.reg_write = 1'b0;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.bubble_clr) begin
            cnt_d = '0;
        end else if (bubble && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ex_alu_src    = ctrl_q.alu_src;
    assign bus.ex_alu_op     = ctrl_q.alu_op;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_mode   = ctrl_q.mem_mode;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_reg_write  = ctrl_q.reg_write;

    assign bus.ex_pc         = data_q.pc;
    assign bus.ex_rs1_data   = data_q.rs1_data;
    assign bus.ex_rs2_data   = data_q.rs2_data;
    assign bus.ex_imm        = data_q.imm;
    assign bus.ex_rs1_addr   = data_q.rs1_addr;
    assign bus.ex_rs2_addr   = data_q.rs2_addr;
    assign bus.ex_rd_addr    = data_q.rd_addr;

    assign bus.ex_valid      = valid_q;
    assign bus.bubble_cnt    = cnt_q;
endmodule
